// File: rtl/axis_arb_defs_pkg.sv
// Shared definitions for the 2-to-1 AXI-Stream arbiter: mode codes,
// grant state encoding and burst counter width.
package axis_arb_defs;

   localparam logic [1:0] MODE_FORCE_A = 2'd0;
   localparam logic [1:0] MODE_FORCE_B = 2'd1;
   localparam logic [1:0] MODE_RR      = 2'd2;

   localparam int unsigned BURST_CNT_W = 16;
   localparam int unsigned SWITCH_W    = 16;

   typedef enum logic {
      SEL_A = 1'b0,
      SEL_B = 1'b1
   } sel_e;

endpackage

// File: rtl/axis_beat_counter.sv
// Wrapping statistics counter; a synchronous clear overrides a coincident increment.
module axis_beat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc)
         count <= count + W'(1);
   end

endmodule

// File: rtl/axis_2to1_arbiter.sv
// Grant controller for a 2-to-1 AXI-Stream mux: round-robin with bounded
// bursts or forced select, switching only at handshake-safe points.
module axis_2to1_arbiter
   import axis_arb_defs::*;
#(
   parameter int unsigned BURST_LEN = 16,
   parameter int unsigned CNT_W     = 32
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic [1:0]          MODE,
   input  logic                clr_stats,
   input  logic                sA_tvalid,
   input  logic                sB_tvalid,
   input  logic                mi_tvalid,
   input  logic                mi_tready,
   output logic                CONF,
   output logic [CNT_W-1:0]    beats_A,
   output logic [CNT_W-1:0]    beats_B,
   output logic [SWITCH_W-1:0] switches
);

   sel_e                   state, state_nxt;
   logic [BURST_CNT_W-1:0] cnt, cnt_nxt;
   logic                   hs, cur_v, oth_v, safe, burst_end, sw;

   // Grant state and burst counter registers
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state <= SEL_A;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next grant: RR yields on idle or exhausted burst; forced modes move at a safe point
   always_comb begin
      hs        = mi_tvalid & mi_tready;
      cur_v     = (state == SEL_B) ? sB_tvalid : sA_tvalid;
      oth_v     = (state == SEL_B) ? sA_tvalid : sB_tvalid;
      safe      = !cur_v | hs;
      burst_end = hs && (cnt == BURST_CNT_W'(BURST_LEN - 1));
      state_nxt = state;
      if (MODE >= MODE_RR) begin
         if (oth_v && (!cur_v || burst_end))
            state_nxt = (state == SEL_A) ? SEL_B : SEL_A;
      end else if (MODE == MODE_FORCE_A) begin
         if (state == SEL_B && safe)
            state_nxt = SEL_A;
      end else begin
         if (state == SEL_A && safe)
            state_nxt = SEL_B;
      end
      sw      = (state_nxt != state);
      cnt_nxt = cnt;
      if (sw || burst_end)
         cnt_nxt = '0;
      else if (hs)
         cnt_nxt = cnt + BURST_CNT_W'(1);
   end

   assign CONF = (state == SEL_B);

   // Beats are credited to the source selected during the handshake cycle
   axis_beat_counter #(.W(CNT_W)) u_beats_a (
      .clk   (ACLK),
      .rst   (ARESET),
      .inc   (hs && state == SEL_A),
      .clr   (clr_stats),
      .count (beats_A)
   );

   axis_beat_counter #(.W(CNT_W)) u_beats_b (
      .clk   (ACLK),
      .rst   (ARESET),
      .inc   (hs && state == SEL_B),
      .clr   (clr_stats),
      .count (beats_B)
   );

   axis_beat_counter #(.W(SWITCH_W)) u_switches (
      .clk   (ACLK),
      .rst   (ARESET),
      .inc   (sw),
      .clr   (clr_stats),
      .count (switches)
   );

endmodule
